// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-wide synchronous RAM.
// Sub-word stores use read-modify-write. Loads are lane-extracted and then sign- or zero-extended.
module lsu #(
  parameter int RAM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd
);

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;
  localparam logic [31:0] LP_WORDS = 32'(RAM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wd;

  logic        w_illegal;
  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_load_val;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  // Rejects any request that must not touch the RAM.
  function automatic logic is_illegal(input logic st, input logic [2:0] f3,
                                      input logic [31:0] a);
    logic bad_f3;
    logic misalign;
    logic out_of_range;
    case (f3)
      F3_B, F3_H, F3_W: bad_f3 = 1'b0;
      F3_BU, F3_HU:     bad_f3 = st;
      default:          bad_f3 = 1'b1;
    endcase
    misalign     = ((f3 == F3_H || f3 == F3_HU) && a[0]) ||
                   (f3 == F3_W && a[1:0] != 2'b00);
    out_of_range = {2'b00, a[31:2]} >= LP_WORDS;
    return bad_f3 || misalign || out_of_range;
  endfunction

  assign ready    = (r_state == S_IDLE);
  assign ram_we   = (r_state == S_WRITE);
  assign ram_addr = ready ? addr : r_addr;
  assign ram_wd   = r_wd;

  assign w_illegal = is_illegal(we, funct3, addr);
  assign w_shift   = {r_addr[1:0], 3'b000};
  assign w_lane    = ram_rd >> w_shift;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    w_load_val = ram_rd;
    case (r_funct3)
      F3_B:    w_load_val = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_H:    w_load_val = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_BU:   w_load_val = {24'h0, w_lane[7:0]};
      F3_HU:   w_load_val = {16'h0, w_lane[15:0]};
      default: w_load_val = ram_rd;
    endcase
  end

  // The byte or halfword store lane is shifted into place. All bytes outside the lane keep the old RAM contents.
  assign w_mask   = ((r_funct3 == F3_B) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
  assign w_merged = (ram_rd & ~w_mask) | ((r_wd << w_shift) & w_mask);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wd     <= 32'h0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            r_funct3 <= funct3;
            r_addr   <= addr;
            r_wd     <= wd;
            if (w_illegal) begin
              r_state <= S_RESP;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (!we) begin
              r_state <= S_LOAD;
            end else if (funct3 == F3_W) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_RMW;
            end
          end
        end
        S_LOAD: begin
          rdata   <= w_load_val;
          done    <= 1'b1;
          r_state <= S_RESP;
        end
        S_RMW: begin
          r_wd    <= w_merged;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          done    <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
